// File: rtl/map_checkpoint_ctrl.sv
// map_checkpoint_ctrl: branch checkpoint controller for the rename stage.
// Each dispatching branch gets a checkpoint ID in program order, along with a
// copy of the rename map table. While a snapshot is live, CDB completions keep
// its ready bits current. A mispredict frees the offending checkpoint and every
// younger one. One cycle later the controller drives a single-cycle restore of
// the saved table.
// Optional build macro: CKPT_PERF_CNT_EN adds saturating perf counters
// (perf_full_stalls, perf_restores).
//
// Handshake: an allocation happens on a rising edge where alloc_req && alloc_ready.
// alloc_ready depends only on registered state and the current resolve inputs,
// never on alloc_req. restore_valid is a one-cycle strobe with no backpressure.

`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 8
`endif
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_W
`define PHYS_REG_W 6
`endif

package map_checkpoint_pkg;
  typedef struct packed {
    logic [`PHYS_REG_W-1:0] phys_reg;
    logic                   ready;
  } MAP_ENTRY;

  typedef struct packed {
    logic                   valid;
    logic [`PHYS_REG_W-1:0] tag;
  } CDB_ENTRY;

  typedef MAP_ENTRY [`ARCH_REG_SZ-1:0] map_table_t;
  typedef CDB_ENTRY [`N-1:0]           cdb_bus_t;
endpackage

module map_checkpoint_ctrl
  import map_checkpoint_pkg::*;
#(
  parameter int NUM_CKPT   = 4,
  parameter int CKPT_IDX_W = $clog2(NUM_CKPT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic [CKPT_IDX_W-1:0] alloc_id,
  input  map_table_t            snapshot_in,
  input  logic                  resolve_valid,
  input  logic [CKPT_IDX_W-1:0] resolve_id,
  input  logic                  resolve_mispredict,
  input  cdb_bus_t              cdb_broadcasts,
  output logic                  restore_valid,
  output map_table_t            restore_table,
  output logic [NUM_CKPT-1:0]   ckpt_valid
`ifdef CKPT_PERF_CNT_EN
  ,
  output logic [31:0]           perf_full_stalls,
  output logic [31:0]           perf_restores
`endif
);

  localparam logic [CKPT_IDX_W-1:0] IDX_ONE = CKPT_IDX_W'(1);

  // Registered state
  map_table_t            r_snap [NUM_CKPT];
  logic [NUM_CKPT-1:0]   r_valid;
  logic [CKPT_IDX_W-1:0] r_head;
  logic [CKPT_IDX_W-1:0] r_tail;
  logic                  r_restore_valid;
  map_table_t            r_restore_table;

  // Combinational decode
  logic                  w_mispredict;
  logic                  w_correct;
  logic                  w_alloc_ready;
  logic                  w_alloc;
  logic [CKPT_IDX_W-1:0] w_dist;
  logic [NUM_CKPT-1:0]   w_kill_mask;
  logic [NUM_CKPT-1:0]   w_valid_nxt;
  logic [CKPT_IDX_W-1:0] w_tail_nxt;
  logic [CKPT_IDX_W-1:0] w_head_nxt;
  logic                  w_head_stop;

  // Force ready on any entry whose physical register completes this cycle.
  function automatic map_table_t cdb_merge(input map_table_t tbl, input cdb_bus_t cdb);
    map_table_t res;
    res = tbl;
    for (int a = 0; a < `ARCH_REG_SZ; a++) begin
      for (int c = 0; c < `N; c++) begin
        if (cdb[c].valid && (cdb[c].tag == tbl[a].phys_reg)) begin
          res[a].ready = 1'b1;
        end
      end
    end
    return res;
  endfunction

  assign w_mispredict  = resolve_valid &&  resolve_mispredict && r_valid[resolve_id];
  assign w_correct     = resolve_valid && !resolve_mispredict && r_valid[resolve_id];
  // A correct resolve in this same cycle does not free a slot early.
  assign w_alloc_ready = !r_valid[r_tail] && !r_restore_valid && !w_mispredict;
  assign w_alloc       = alloc_req && w_alloc_ready;

  assign alloc_ready   = w_alloc_ready;
  assign alloc_id      = r_tail;
  assign ckpt_valid    = r_valid;
  assign restore_valid = r_restore_valid;
  assign restore_table = r_restore_table;

  // Slots from resolve_id up to tail-1 (cyclic) are the mispredicting branch and all younger ones.
  // A zero distance means the tail has wrapped onto a live slot, so every slot is killed.
  always_comb begin
    logic [CKPT_IDX_W-1:0] slot;
    w_kill_mask = '0;
    w_dist      = r_tail - resolve_id;
    slot        = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      slot = resolve_id + i[CKPT_IDX_W-1:0];
      if ((w_dist == '0) || (i < int'(w_dist))) begin
        w_kill_mask[slot] = 1'b1;
      end
    end
  end

  // Next live bits and next tail. Alloc, correct-free and mispredict never hit the same slot.
  always_comb begin
    w_valid_nxt = r_valid;
    w_tail_nxt  = r_tail;
    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
      w_tail_nxt          = r_tail + IDX_ONE;
    end
    if (w_correct) begin
      w_valid_nxt[resolve_id] = 1'b0;
    end
    if (w_mispredict) begin
      w_valid_nxt = r_valid & ~w_kill_mask;
      w_tail_nxt  = resolve_id;
    end
  end

  // Move the oldest-live pointer past freed slots, stopping at the tail or a live slot.
  always_comb begin
    w_head_nxt  = r_head;
    w_head_stop = 1'b0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (!w_head_stop) begin
        if ((w_head_nxt == w_tail_nxt) || w_valid_nxt[w_head_nxt]) begin
          w_head_stop = 1'b1;
        end else begin
          w_head_nxt = w_head_nxt + IDX_ONE;
        end
      end
    end
  end

  // Pointer, live-bit and restore registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_restore_valid <= 1'b0;
      r_restore_table <= '0;
    end else begin
      r_valid         <= w_valid_nxt;
      r_head          <= w_head_nxt;
      r_tail          <= w_tail_nxt;
      r_restore_valid <= w_mispredict;
      if (w_mispredict) begin
        r_restore_table <= cdb_merge(r_snap[resolve_id], cdb_broadcasts);
      end
    end
  end

  // Snapshot storage: capture on allocation, otherwise keep live snapshots' ready bits current.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (w_alloc && (r_tail == s[CKPT_IDX_W-1:0])) begin
        r_snap[s] <= cdb_merge(snapshot_in, cdb_broadcasts);
      end else if (r_valid[s]) begin
        r_snap[s] <= cdb_merge(r_snap[s], cdb_broadcasts);
      end
    end
  end

`ifdef CKPT_PERF_CNT_EN
  logic [31:0] r_perf_full_stalls;
  logic [31:0] r_perf_restores;

  // Saturating counters: stalls caused by a full ring, and restore pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_full_stalls <= '0;
      r_perf_restores    <= '0;
    end else begin
      if (alloc_req && r_valid[r_tail] && (r_perf_full_stalls != 32'hFFFF_FFFF)) begin
        r_perf_full_stalls <= r_perf_full_stalls + 32'd1;
      end
      if (r_restore_valid && (r_perf_restores != 32'hFFFF_FFFF)) begin
        r_perf_restores <= r_perf_restores + 32'd1;
      end
    end
  end

  assign perf_full_stalls = r_perf_full_stalls;
  assign perf_restores    = r_perf_restores;
`endif

endmodule

// File: tb/tb_map_checkpoint_ctrl.sv
// Testbench for map_checkpoint_ctrl: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a slot-array reference model.

`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 8
`endif
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_W
`define PHYS_REG_W 6
`endif

module tb_map_checkpoint_ctrl;
  import map_checkpoint_pkg::*;

  localparam int NC = 4;
  localparam int AR = `ARCH_REG_SZ;
  localparam int NB = `N;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_ready;
  logic [1:0] alloc_id;
  map_table_t snapshot_in = '0;
  logic       resolve_valid = 1'b0;
  logic [1:0] resolve_id = '0;
  logic       resolve_mispredict = 1'b0;
  cdb_bus_t   cdb_broadcasts = '0;
  logic       restore_valid;
  map_table_t restore_table;
  logic [3:0] ckpt_valid;
`ifdef CKPT_PERF_CNT_EN
  logic [31:0] perf_full_stalls;
  logic [31:0] perf_restores;
`endif

  always #5 clock = ~clock;

  map_checkpoint_ctrl #(.NUM_CKPT(NC)) dut (
    .clock              (clock),
    .reset              (reset),
    .alloc_req          (alloc_req),
    .alloc_ready        (alloc_ready),
    .alloc_id           (alloc_id),
    .snapshot_in        (snapshot_in),
    .resolve_valid      (resolve_valid),
    .resolve_id         (resolve_id),
    .resolve_mispredict (resolve_mispredict),
    .cdb_broadcasts     (cdb_broadcasts),
    .restore_valid      (restore_valid),
    .restore_table      (restore_table),
    .ckpt_valid         (ckpt_valid)
`ifdef CKPT_PERF_CNT_EN
    ,
    .perf_full_stalls   (perf_full_stalls),
    .perf_restores      (perf_restores)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot is modelled as a list of (phys, ready) pairs plus a live flag.
  bit          m_valid [NC];
  int          m_tail;
  int          m_phys  [NC][AR];
  bit          m_rdy   [NC][AR];
  bit          m_rv;
  int          m_rt_phys [AR];
  bit          m_rt_rdy  [AR];
  logic [31:0] m_full_stalls;
  logic [31:0] m_restores;

  function automatic bit tag_hit(input int p);
    for (int c = 0; c < NB; c++) begin
      if (cdb_broadcasts[c].valid && (int'(cdb_broadcasts[c].tag) == p)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_ready();
    bit mis;
    mis = resolve_valid && resolve_mispredict && m_valid[int'(resolve_id)];
    return !m_valid[m_tail] && !m_rv && !mis;
  endfunction

  function automatic logic [63:0] model_table();
    map_table_t t;
    for (int a = 0; a < AR; a++) begin
      t[a].phys_reg = `PHYS_REG_W'(m_rt_phys[a]);
      t[a].ready    = m_rt_rdy[a];
    end
    return 64'(t);
  endfunction

  function automatic logic [63:0] model_live();
    logic [3:0] v;
    for (int s = 0; s < NC; s++) v[s] = m_valid[s];
    return 64'(v);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NC; s++) m_valid[s] = 1'b0;
    m_tail = 0;
    m_rv   = 1'b0;
    for (int a = 0; a < AR; a++) begin
      m_rt_phys[a] = 0;
      m_rt_rdy[a]  = 1'b0;
    end
    m_full_stalls = '0;
    m_restores    = '0;
  endtask

  task automatic model_step();
    bit mis, cor, alc;
    int k, j;
    k   = int'(resolve_id);
    mis = resolve_valid &&  resolve_mispredict && m_valid[k];
    cor = resolve_valid && !resolve_mispredict && m_valid[k];
    alc = alloc_req && model_ready();
    if (alloc_req && m_valid[m_tail] && (m_full_stalls != 32'hFFFF_FFFF)) m_full_stalls++;
    if (m_rv && (m_restores != 32'hFFFF_FFFF)) m_restores++;
    if (mis) begin
      for (int a = 0; a < AR; a++) begin
        m_rt_phys[a] = m_phys[k][a];
        m_rt_rdy[a]  = m_rdy[k][a] | tag_hit(m_phys[k][a]);
      end
    end
    m_rv = mis;
    for (int s = 0; s < NC; s++) begin
      if (m_valid[s]) begin
        for (int a = 0; a < AR; a++) begin
          if (tag_hit(m_phys[s][a])) m_rdy[s][a] = 1'b1;
        end
      end
    end
    if (alc) begin
      for (int a = 0; a < AR; a++) begin
        m_phys[m_tail][a] = int'(snapshot_in[a].phys_reg);
        m_rdy[m_tail][a]  = snapshot_in[a].ready | tag_hit(int'(snapshot_in[a].phys_reg));
      end
      m_valid[m_tail] = 1'b1;
      m_tail = (m_tail + 1) % NC;
    end
    if (cor) m_valid[k] = 1'b0;
    if (mis) begin
      j = k;
      do begin
        m_valid[j] = 1'b0;
        j = (j + 1) % NC;
      end while (j != m_tail);
      m_tail = k;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      #2;
      if (reset) model_reset();
      chk("alloc_ready",   64'(alloc_ready),   64'(model_ready()));
      chk("alloc_id",      64'(alloc_id),      64'(m_tail));
      chk("ckpt_valid",    64'(ckpt_valid),    model_live());
      chk("restore_valid", 64'(restore_valid), 64'(m_rv));
      chk("restore_table", 64'(restore_table), model_table());
`ifdef CKPT_PERF_CNT_EN
      chk("perf_full_stalls", 64'(perf_full_stalls), 64'(m_full_stalls));
      chk("perf_restores",    64'(perf_restores),    64'(m_restores));
`endif
      if (!reset) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  map_table_t s_snap;
  cdb_bus_t   s_cdb;

  task automatic drive(input bit a, input bit rv, input int rid, input bit mis);
    logic [1:0] id;
    id = rid[1:0];
    @(negedge clock);
    alloc_req          = a;
    resolve_valid      = rv;
    resolve_id         = id;
    resolve_mispredict = mis;
    snapshot_in        = s_snap;
    cdb_broadcasts     = s_cdb;
  endtask

  task automatic base_snap();
    for (int a = 0; a < AR; a++) begin
      s_snap[a].phys_reg = `PHYS_REG_W'(a + 1);
      s_snap[a].ready    = 1'b0;
    end
    s_cdb = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    cdb_broadcasts = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  MAP_ENTRY e_exp;

  initial begin
    base_snap();
    do_reset();

    // Back-to-back allocation until full
    for (int i = 0; i < NC; i++) begin
      drive(1, 0, 0, 0); #3;
      chk("fill_alloc_id", 64'(alloc_id), 64'(i));
      chk("fill_ready",    64'(alloc_ready), 64'd1);
    end
    drive(1, 0, 0, 0); #3;
    chk("full_ready", 64'(alloc_ready), 64'd0);
    chk("full_valid", 64'(ckpt_valid),  64'hF);

    // Out-of-order correct frees
    drive(0, 1, 2, 0);
    drive(0, 0, 0, 0); #3;
    chk("free2_valid", 64'(ckpt_valid),  64'hB);
    chk("free2_ready", 64'(alloc_ready), 64'd0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0); #3;
    chk("free0_ready", 64'(alloc_ready), 64'd1);
    chk("free0_id",    64'(alloc_id),    64'd0);
    chk("free0_valid", 64'(ckpt_valid),  64'hA);

    // Ready bit picked up from CDB while stored, then restored
    do_reset();
    base_snap();
    drive(1, 0, 0, 0);
    s_snap[5].phys_reg = `PHYS_REG_W'(40);
    s_snap[5].ready    = 1'b0;
    drive(1, 0, 0, 0);
    base_snap();
    drive(0, 0, 0, 0);
    s_cdb[0].valid = 1'b1;
    s_cdb[0].tag   = `PHYS_REG_W'(40);
    drive(0, 0, 0, 0);
    s_cdb = '0;
    drive(0, 1, 1, 1);
    drive(0, 0, 0, 0); #3;
    e_exp.phys_reg = `PHYS_REG_W'(40);
    e_exp.ready    = 1'b1;
    chk("cdb_restore_valid", 64'(restore_valid),    64'd1);
    chk("cdb_restore_e5",    64'(restore_table[5]), 64'(e_exp));
    chk("cdb_live",          64'(ckpt_valid),       64'h1);
    chk("cdb_restore_block", 64'(alloc_ready),      64'd0);
    drive(0, 0, 0, 0); #3;
    chk("cdb_pulse_once",    64'(restore_valid),    64'd0);
    chk("cdb_after_id",      64'(alloc_id),         64'd1);

    // Mispredict flushes younger slots
    do_reset();
    for (int i = 0; i < NC; i++) drive(1, 0, 0, 0);
    drive(0, 1, 1, 1);
    drive(0, 0, 0, 0); #3;
    chk("flush_live",  64'(ckpt_valid),    64'h1);
    chk("flush_pulse", 64'(restore_valid), 64'd1);
    drive(0, 0, 0, 0); #3;
    chk("flush_pulse_end", 64'(restore_valid), 64'd0);
    chk("flush_id",        64'(alloc_id),      64'd1);
    chk("flush_ready",     64'(alloc_ready),   64'd1);

    // CDB hit in the allocation cycle; mispredict on an invalid slot is ignored
    do_reset();
    base_snap();
    s_snap[3].phys_reg = `PHYS_REG_W'(12);
    s_cdb[1].valid = 1'b1;
    s_cdb[1].tag   = `PHYS_REG_W'(12);
    drive(1, 0, 0, 0);
    base_snap();
    drive(0, 1, 2, 1);
    drive(0, 0, 0, 0); #3;
    chk("inv_mis_no_restore", 64'(restore_valid), 64'd0);
    chk("inv_mis_live",       64'(ckpt_valid),    64'h1);
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 0); #3;
    e_exp.phys_reg = `PHYS_REG_W'(12);
    e_exp.ready    = 1'b1;
    chk("same_cycle_cdb_e3", 64'(restore_table[3]), 64'(e_exp));

    // Asynchronous reset in the middle of a restore pulse
    do_reset();
    base_snap();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 1);
    @(posedge clock); #2;
    chk("mid_pre_restore", 64'(restore_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_rv",    64'(restore_valid), 64'd0);
    chk("async_rst_live",  64'(ckpt_valid),    64'd0);
    chk("async_rst_id",    64'(alloc_id),      64'd0);
    chk("async_rst_table", 64'(restore_table), 64'd0);
`ifdef CKPT_PERF_CNT_EN
    chk("async_rst_stalls",   64'(perf_full_stalls), 64'd0);
    chk("async_rst_restores", 64'(perf_restores),    64'd0);
`endif
    @(negedge clock);
    alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic, checked each cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      for (int a = 0; a < AR; a++) begin
        s_snap[a].phys_reg = `PHYS_REG_W'($urandom_range(0, 15));
        s_snap[a].ready    = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < NB; c++) begin
        s_cdb[c].valid = ($urandom_range(0, 99) < 50);
        s_cdb[c].tag   = `PHYS_REG_W'($urandom_range(0, 15));
      end
      drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 40),
            int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 15));
    end

    @(negedge clock);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
